// File: rtl/ntt_scheduler.sv
// ntt_scheduler: round-robin sharing of one ntt core between N_REQ requesters.
// Latency: req seen in IDLE -> grant/core_start next cycle; core_valid -> done next cycle; 1 IDLE cycle between grants.
// Backpressure: one job in flight; requesters hold req until done (or grant drop after watchdog expiry).
// Ports: clk/rst (async active-high); req/req_inv requester side; grant/sel/done per-requester outputs;
//        core_start/core_inv/core_valid core handshake; busy status; timeout_err sticky watchdog flag, err_clr clears it.
module ntt_scheduler #(
    parameter int N_REQ   = 3,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_inv,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   sel,
    output logic             core_start,
    output logic             core_inv,
    input  logic             core_valid,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   sel_q, sel_d;
    logic             core_start_q, core_start_d;
    logic             core_inv_q, core_inv_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic             wd_expire;

    // Round-robin pick: scan from the highest offset down so the last hit,
    // i.e. the smallest offset from rr_q, is the one that sticks.
    always_comb begin : rr_pick
        logic [IDW:0] cand;
        cand     = '0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (IDW + 1)'(i);
            if (cand >= (IDW + 1)'(N_REQ)) begin
                cand = cand - (IDW + 1)'(N_REQ);
            end
            if (req[cand[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        core_inv_d   = core_inv_q;
        core_start_d = 1'b0;
        done_d       = '0;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        wd_expire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d      = ST_LAUNCH;
                    for (int i = 0; i < N_REQ; i++) begin
                        grant_d[i] = (pick_id == IDW'(i));
                    end
                    sel_d        = pick_id;
                    core_inv_d   = req_inv[pick_id];
                    core_start_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // A valid in the terminal-count cycle still counts as completion.
                if (core_valid) begin
                    state_d = ST_RELEASE;
                    done_d  = grant_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_RELEASE;
                    wd_expire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                // grant/sel/core_inv stay up this cycle so the owner can take the core output.
                state_d    = ST_IDLE;
                grant_d    = '0;
                sel_d      = '0;
                core_inv_d = 1'b0;
                rr_d       = (sel_q == IDW'(N_REQ - 1)) ? '0 : sel_q + IDW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Expiry beats a same-cycle clear so an error is never lost.
        timeout_err_d = wd_expire | (timeout_err_q & ~err_clr);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            sel_q         <= '0;
            core_start_q  <= 1'b0;
            core_inv_q    <= 1'b0;
            done_q        <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            rr_q          <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            core_start_q  <= core_start_d;
            core_inv_q    <= core_inv_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign core_start  = core_start_q;
    assign core_inv    = core_inv_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ntt_scheduler.sv
// tb_ntt_scheduler: scoreboard bench for ntt_scheduler with a behavioural ntt core model.
// Latency: core model raises core_valid a programmable number of cycles after core_start.
// Backpressure: requesters drop req on done, or on grant fall after a watchdog expiry.
module tb_ntt_scheduler;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] req_inv;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       core_start;
    logic       core_inv;
    logic       core_valid;
    logic [2:0] done;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;

    ntt_scheduler #(.N_REQ(3), .IDW(2), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_inv     (req_inv),
        .grant       (grant),
        .sel         (sel),
        .core_start  (core_start),
        .core_inv    (core_inv),
        .core_valid  (core_valid),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    typedef struct {
        int id;
        bit inv;
        bit completes;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   core_delay = 0;   // 0 means the core never answers

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "tb_ntt_scheduler hung");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (done == 3'b000 && n < limit) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check_eq("wait_done_bound", 32'(done != 3'b000), 1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(req == 3'b000 && busy == 1'b0) && n < limit) begin
            tick();
            n++;
        end
        check_eq("wait_idle_bound", 32'(req == 3'b000 && busy == 1'b0), 1);
        repeat (2) tick();
    endtask

    // Behavioural core: valid pulses core_delay cycles after the start cycle.
    initial begin
        int rem;
        rem = 0;
        core_valid = 1'b0;
        forever begin
            @(negedge clk);
            core_valid = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) core_valid = 1'b1;
            end
            if (core_start === 1'b1 && core_delay > 0) rem = core_delay;
        end
    end

    // Service monitor / scoreboard, plus requester behaviour (drop req on done or grant fall).
    initial begin
        bit         in_svc;
        bit         stable;
        logic [1:0] s_sel;
        logic [2:0] s_grant;
        logic       s_inv;
        logic [2:0] s_done;
        exp_t       e;
        in_svc = 1'b0;
        stable = 1'b1;
        s_sel = '0; s_grant = '0; s_inv = 1'b0; s_done = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_svc = 1'b0;
                continue;
            end
            if (core_start === 1'b1) begin
                in_svc  = 1'b1;
                stable  = 1'b1;
                s_sel   = sel;
                s_grant = grant;
                s_inv   = core_inv;
                s_done  = '0;
            end else if (in_svc) begin
                if (grant == 3'b000) begin
                    in_svc = 1'b0;
                    req[s_sel] = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_unexpected_service", 32'(s_sel), 32'hFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("sb_id", 32'(s_sel), e.id);
                        check_eq("sb_grant", 32'(s_grant), 32'(1) << e.id);
                        check_eq("sb_inv", 32'(s_inv), 32'(e.inv));
                        check_eq("sb_done", 32'(s_done), e.completes ? (32'(1) << e.id) : 0);
                        check_eq("sb_held_stable", 32'(stable), 1);
                    end
                end else begin
                    if (sel != s_sel || grant != s_grant || core_inv != s_inv) stable = 1'b0;
                    s_done = s_done | done;
                    req = req & ~done;
                end
            end
        end
    end

    initial begin
        int n;
        bit busy_ok;

        rst = 1'b1; req = '0; req_inv = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_sel", 32'(sel), 0);
        check_eq("rst_core_start", 32'(core_start), 0);
        check_eq("rst_core_inv", 32'(core_inv), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic forward service, core answers 15 cycles after start.
        exp_q.push_back('{0, 1'b0, 1'b1});
        core_delay = 15;
        req = 3'b001;
        tick();
        check_eq("fwd_grant", 32'(grant), 32'b001);
        check_eq("fwd_sel", 32'(sel), 0);
        check_eq("fwd_start", 32'(core_start), 1);
        check_eq("fwd_busy", 32'(busy), 1);
        check_eq("fwd_inv", 32'(core_inv), 0);
        wait_done(100, n, busy_ok);
        check_eq("fwd_done_latency", n, 16);
        check_eq("fwd_busy_held", 32'(busy_ok), 1);
        check_eq("fwd_done", 32'(done), 32'b001);
        tick();
        check_eq("fwd_grant_drop", 32'(grant), 0);
        check_eq("fwd_done_pulse", 32'(done), 0);
        check_eq("fwd_busy_drop", 32'(busy), 0);
        wait_idle(50);

        // Pointer is 1: requester 2 goes before requester 0.
        exp_q.push_back('{2, 1'b0, 1'b1});
        exp_q.push_back('{0, 1'b0, 1'b1});
        core_delay = 5;
        req = 3'b101;
        wait_idle(300);

        // Inverse on requester 2; direction changes after grant are ignored.
        exp_q.push_back('{2, 1'b1, 1'b1});
        core_delay = 15;
        req_inv = 3'b100;
        req = 3'b100;
        tick();
        check_eq("inv_sel", 32'(sel), 2);
        check_eq("inv_core_inv", 32'(core_inv), 1);
        req_inv = 3'b000;
        wait_done(100, n, busy_ok);
        check_eq("inv_core_inv_release", 32'(core_inv), 1);
        tick();
        check_eq("inv_core_inv_idle", 32'(core_inv), 0);
        wait_idle(50);

        // Fairness from pointer 0, twice.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back('{i, 1'b0, 1'b1});
            core_delay = 4;
            req = 3'b111;
            wait_idle(300);
        end

        // Watchdog: requester 0 never answered, requester 1 pending.
        exp_q.push_back('{0, 1'b0, 1'b0});
        exp_q.push_back('{1, 1'b0, 1'b1});
        core_delay = 0;
        req = 3'b011;
        tick();
        check_eq("wd_grant", 32'(grant), 32'b001);
        n = 0;
        while (timeout_err == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check_eq("wd_cycles", n, 65);
        check_eq("wd_err", 32'(timeout_err), 1);
        check_eq("wd_no_done", 32'(done), 0);
        check_eq("wd_grant_held", 32'(grant), 32'b001);
        core_delay = 10;
        tick();
        check_eq("wd_grant_drop", 32'(grant), 0);
        tick();
        check_eq("wd_pending_grant", 32'(grant), 32'b010);
        wait_done(100, n, busy_ok);
        check_eq("wd_pending_done", 32'(done), 32'b010);
        check_eq("wd_err_sticky", 32'(timeout_err), 1);
        wait_idle(50);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("wd_err_clear", 32'(timeout_err), 0);

        // Valid exactly at the terminal count: completion, no error.
        exp_q.push_back('{0, 1'b0, 1'b1});
        core_delay = 64;
        req = 3'b001;
        tick();
        check_eq("tc_grant", 32'(grant), 32'b001);
        wait_done(100, n, busy_ok);
        check_eq("tc_latency", n, 65);
        check_eq("tc_done", 32'(done), 32'b001);
        check_eq("tc_no_err", 32'(timeout_err), 0);
        wait_idle(50);

        // Reset mid-WAIT, pointer at 1 beforehand.
        core_delay = 30;
        req = 3'b100;
        tick();
        check_eq("rw_grant", 32'(grant), 32'b100);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rw_grant_async", 32'(grant), 0);
        check_eq("rw_busy_async", 32'(busy), 0);
        check_eq("rw_start_async", 32'(core_start), 0);
        check_eq("rw_sel_async", 32'(sel), 0);
        req = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 3'b000 || grant !== 3'b000) busy_ok = 1'b0;
        end
        check_eq("rw_stale_valid_ignored", 32'(busy_ok), 1);
        exp_q.push_back('{0, 1'b0, 1'b1});
        exp_q.push_back('{1, 1'b0, 1'b1});
        core_delay = 8;
        req = 3'b011;
        tick();
        check_eq("rw_first_after_reset", 32'(grant), 32'b001);
        wait_idle(300);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
